// File: rtl/axi_wr_arbiter.sv
// axi_wr_arbiter: shares one AXI write channel (AW/W/B) between N requesters.
// Round-robin grant per transaction, held from AW request to B handshake.
// WLAST is generated locally from the captured burst length.
module axi_wr_arbiter #(
  parameter int N  = 2,
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [N-1:0]        s_awvalid,
  output logic [N-1:0]        s_awready,
  input  logic [N*AW-1:0]     s_awaddr,
  input  logic [N*8-1:0]      s_awlen,
  input  logic [N-1:0]        s_wvalid,
  output logic [N-1:0]        s_wready,
  input  logic [N*DW-1:0]     s_wdata,
  input  logic [N*(DW/8)-1:0] s_wstrb,
  output logic [N-1:0]        s_bvalid,
  input  logic [N-1:0]        s_bready,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [AW-1:0]       m_awaddr,
  output logic [7:0]          m_awlen,
  output logic                m_wvalid,
  input  logic                m_wready,
  output logic [DW-1:0]       m_wdata,
  output logic [DW/8-1:0]     m_wstrb,
  output logic                m_wlast,
  input  logic                m_bvalid,
  output logic                m_bready
);

  localparam int GW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = DW / 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] rr_ptr_q, rr_ptr_d;
  logic [7:0]    beat_cnt_q, beat_cnt_d;
  logic [7:0]    len_q, len_d;

  logic [GW-1:0] pick;
  logic          pick_vld;
  logic [GW:0]   rr_sum;
  logic [7:0]    pick_len;

  logic          g_awvalid, g_wvalid, g_bready;
  logic [AW-1:0] g_awaddr;
  logic [7:0]    g_awlen;
  logic [DW-1:0] g_wdata;
  logic [SW-1:0] g_wstrb;

  // Round-robin search: first requesting index at or above rr_ptr, wrapping at N.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    rr_sum   = '0;
    for (int k = 0; k < N; k++) begin
      rr_sum = {1'b0, rr_ptr_q} + (GW+1)'(k);
      if (rr_sum >= (GW+1)'(N)) rr_sum = rr_sum - (GW+1)'(N);
      if (!pick_vld && s_awvalid[rr_sum[GW-1:0]]) begin
        pick_vld = 1'b1;
        pick     = rr_sum[GW-1:0];
      end
    end
  end

  // Slice muxes: granted requester's channel fields and the candidate's burst length.
  always_comb begin
    g_awvalid = 1'b0;
    g_wvalid  = 1'b0;
    g_bready  = 1'b0;
    g_awaddr  = '0;
    g_awlen   = '0;
    g_wdata   = '0;
    g_wstrb   = '0;
    pick_len  = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_q == GW'(i)) begin
        g_awvalid = s_awvalid[i];
        g_wvalid  = s_wvalid[i];
        g_bready  = s_bready[i];
        g_awaddr  = s_awaddr[i*AW +: AW];
        g_awlen   = s_awlen[i*8 +: 8];
        g_wdata   = s_wdata[i*DW +: DW];
        g_wstrb   = s_wstrb[i*SW +: SW];
      end
      if (pick == GW'(i)) pick_len = s_awlen[i*8 +: 8];
    end
  end

  // Output steering: only the phase owned by the current state reaches either side.
  always_comb begin
    s_awready = '0;
    s_wready  = '0;
    s_bvalid  = '0;
    m_awvalid = 1'b0;
    m_wvalid  = 1'b0;
    m_wlast   = 1'b0;
    m_bready  = 1'b0;
    m_awaddr  = g_awaddr;
    m_awlen   = g_awlen;
    m_wdata   = g_wdata;
    m_wstrb   = g_wstrb;
    case (state_q)
      ADDR: begin
        m_awvalid          = g_awvalid;
        s_awready[grant_q] = m_awready;
      end
      DATA: begin
        m_wvalid          = g_wvalid;
        m_wlast           = (beat_cnt_q == len_q);
        s_wready[grant_q] = m_wready;
      end
      RESP: begin
        m_bready          = g_bready;
        s_bvalid[grant_q] = m_bvalid;
      end
      default: ;
    endcase
  end

  // Transaction sequencing: arbitrate, AW, W beats until local last, then B.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    len_d      = len_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d    = pick;
          len_d      = pick_len;
          beat_cnt_d = '0;
          state_d    = ADDR;
        end
      end
      ADDR: begin
        if (g_awvalid && m_awready) state_d = DATA;
      end
      DATA: begin
        if (g_wvalid && m_wready) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          if (beat_cnt_q == len_q) state_d = RESP;
        end
      end
      RESP: begin
        if (m_bvalid && g_bready) begin
          state_d  = IDLE;
          // The requester just served drops to lowest priority.
          rr_ptr_d = (grant_q == GW'(N-1)) ? '0 : grant_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      len_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      len_q      <= len_d;
    end
  end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Randomized bench for axi_wr_arbiter: requester agents and an AXI slave are
// driven cycle by cycle; a transaction-level model tracks who owns the channel.
module tb_axi_wr_arbiter;
  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic              clk = 1'b0;
  logic              rstn;
  logic [N-1:0]      s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [N*AW-1:0]   s_awaddr;
  logic [N*8-1:0]    s_awlen;
  logic [N*DW-1:0]   s_wdata;
  logic [N*SW-1:0]   s_wstrb;
  logic              m_awvalid, m_awready, m_wvalid, m_wready, m_wlast, m_bvalid, m_bready;
  logic [AW-1:0]     m_awaddr;
  logic [7:0]        m_awlen;
  logic [DW-1:0]     m_wdata;
  logic [SW-1:0]     m_wstrb;

  always #5 clk = ~clk;

  axi_wr_arbiter #(.N(N), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rstn(rstn),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_wlast(m_wlast), .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Transaction-level model state
  int            ptr;
  int            g_cur;
  bit            a_want [N];
  int            a_dly  [N];
  bit            a_aw   [N];
  int            a_beats[N];
  int            a_len  [N];
  logic [AW-1:0] a_addr [N];
  logic [DW-1:0] a_data [N][8];
  logic [SW-1:0] a_strb [N][8];
  bit            bpend, bstart, abort_req;
  int            abort_at;

  function automatic logic [63:0] all_outs();
    return 64'({m_awvalid, m_wvalid, m_wlast, m_bready, s_awready, s_wready, s_bvalid});
  endfunction

  task automatic zero_inputs();
    s_awvalid = '0; s_wvalid = '0; s_bready = '0;
    s_awaddr = '0; s_awlen = '0; s_wdata = '0; s_wstrb = '0;
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0;
  endtask

  task automatic model_reset();
    ptr = 0; g_cur = -1; bpend = 0; bstart = 0; abort_req = 0;
    for (int i = 0; i < N; i++) begin
      a_want[i] = 0; a_aw[i] = 0; a_beats[i] = 0; a_dly[i] = 0;
    end
  endtask

  // Requester agents and slave: set inputs for the current cycle.
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bit act;
      act = a_want[i] && (a_dly[i] == 0);
      s_awvalid[i] = act && !a_aw[i];
      s_awaddr[i*AW +: AW] = a_addr[i];
      s_awlen[i*8 +: 8] = 8'(a_len[i]);
      if (act && a_beats[i] <= a_len[i]) begin
        s_wvalid[i] = ($urandom_range(0, 3) != 0);
        s_wdata[i*DW +: DW] = a_data[i][a_beats[i]];
        s_wstrb[i*SW +: SW] = a_strb[i][a_beats[i]];
      end else begin
        // Finished requesters keep offering a bogus beat; it must stall.
        s_wvalid[i] = act;
        s_wdata[i*DW +: DW] = $urandom;
        s_wstrb[i*SW +: SW] = SW'($urandom);
      end
      s_bready[i] = act && ($urandom_range(0, 2) != 0);
    end
    m_awready = ($urandom_range(0, 2) != 0);
    m_wready  = ($urandom_range(0, 1) != 0);
    m_bvalid  = bpend && (bstart || ($urandom_range(0, 1) != 0));
    if (m_bvalid) bstart = 1;
  endtask

  // Observe one cycle and advance the model on the handshakes about to happen.
  task automatic step();
    logic [N-1:0] gm;
    int g;
    if (g_cur < 0) begin
      check("idle_quiet", all_outs(), 64'd0);
      for (int k = 0; k < N; k++) begin
        int j;
        j = (ptr + k) % N;
        if (g_cur < 0 && s_awvalid[j]) g_cur = j;
      end
    end else begin
      g = g_cur;
      gm = '0;
      gm[g] = 1'b1;
      check("ungranted_quiet", 64'((s_awready | s_wready | s_bvalid) & ~gm), 64'd0);
      if (!a_aw[g]) begin
        check("awvalid_fwd", m_awvalid, s_awvalid[g]);
        check("awready_fwd", s_awready[g], m_awready);
        check("no_w_before_aw", 64'({m_wvalid, s_wready[g], m_bready}), 64'd0);
        if (m_awvalid && m_awready) begin
          check("awaddr", m_awaddr, a_addr[g]);
          check("awlen", m_awlen, 8'(a_len[g]));
          a_aw[g] = 1;
        end
      end else if (a_beats[g] <= a_len[g]) begin
        check("wvalid_fwd", m_wvalid, s_wvalid[g]);
        check("wready_fwd", s_wready[g], m_wready);
        check("wlast", m_wlast, a_beats[g] == a_len[g]);
        check("data_phase_quiet", 64'({m_awvalid, m_bready}), 64'd0);
        if (m_wvalid && m_wready) begin
          check("wdata", m_wdata, a_data[g][a_beats[g]]);
          check("wstrb", m_wstrb, a_strb[g][a_beats[g]]);
          a_beats[g]++;
          if (a_beats[g] > a_len[g]) begin bpend = 1; bstart = 0; end
          if (a_beats[g] == abort_at) abort_req = 1;
        end
      end else begin
        check("resp_quiet", 64'({m_awvalid, m_wvalid, s_wready[g]}), 64'd0);
        check("bready_fwd", m_bready, s_bready[g]);
        check("bvalid_fwd", s_bvalid[g], m_bvalid);
        if (m_bvalid && m_bready) begin
          a_want[g] = 0; bpend = 0; bstart = 0;
          ptr = (g + 1) % N;
          g_cur = -1;
        end
      end
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rstn = 1'b0;
    zero_inputs();
    @(negedge clk);
    check("reset_quiet", all_outs(), 64'd0);
    rstn = 1'b1;
    #1;
    check("post_reset_quiet", all_outs(), 64'd0);
    model_reset();
  endtask

  task automatic run_round(input logic [N-1:0] mask, input int fixlen, input bit stagger,
                           input int abort_beats);
    bit done;
    int cyc;
    abort_at = abort_beats;
    for (int i = 0; i < N; i++) begin
      if (mask[i]) begin
        a_want[i] = 1; a_aw[i] = 0; a_beats[i] = 0;
        a_len[i]  = (fixlen >= 0) ? fixlen : int'($urandom_range(0, 7));
        a_addr[i] = ($urandom & 32'hFFFF_FFF0) | AW'(i);
        a_dly[i]  = stagger ? int'($urandom_range(0, 6)) : 0;
        for (int b = 0; b < 8; b++) begin
          a_data[i][b] = $urandom;
          a_strb[i][b] = SW'($urandom);
        end
      end
    end
    done = 0;
    cyc = 0;
    while (!done && cyc < 600) begin
      @(negedge clk);
      drive();
      #1;
      step();
      for (int i = 0; i < N; i++) if (a_want[i] && a_dly[i] > 0) a_dly[i]--;
      cyc++;
      if (abort_req) begin
        reset_dut();
        done = 1;
      end else begin
        done = (g_cur < 0);
        for (int i = 0; i < N; i++) if (a_want[i]) done = 0;
      end
    end
    check("round_done", done, 1'b1);
    if (!done) reset_dut();
  endtask

  initial begin
    rstn = 1'b0;
    zero_inputs();
    model_reset();
    // Requests held during reset must not leak through.
    s_awvalid = '1;
    repeat (2) @(negedge clk);
    check("in_reset_quiet", all_outs(), 64'd0);
    reset_dut();

    run_round(2'b11, -1, 0, -1);   // simultaneous: 0 then 1
    run_round(2'b11, -1, 0, -1);   // pointer back at 0: 0 first again
    run_round(2'b01, 3, 0, -1);    // write-back burst of 4
    run_round(2'b10, 0, 0, -1);    // single-beat uncached store
    run_round(2'b01, 3, 0, 2);     // reset after 2 data beats
    run_round(2'b10, 1, 0, -1);    // restart after abort
    run_round(2'b01, 2, 0, -1);
    for (int r = 0; r < 60; r++)
      run_round(N'($urandom_range(1, (1 << N) - 1)), -1, 1'b1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
